// File: rtl/hilo_muldiv_pkg.sv
// Shared constants, encodings and sign helpers for the HI/LO multiply/divide controller.
// Build macro HILO_MULDIV_DIV_EN enables the divider; without it DIV/DIVU act as reserved codes.
package hilo_muldiv_pkg;

    localparam int XLEN   = 32;
    localparam int ITER_N = 32;
    localparam int CNT_W  = 5;
    localparam logic [CNT_W-1:0] CNT_LAST = 5'd31;

`ifdef HILO_MULDIV_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    typedef enum logic [2:0] {
        OP_MULT  = 3'd0,
        OP_MULTU = 3'd1,
        OP_DIV   = 3'd2,
        OP_DIVU  = 3'd3,
        OP_MTHI  = 3'd4,
        OP_MTLO  = 3'd5
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2
    } state_e;

    function automatic logic [XLEN-1:0] neg_if(input logic [XLEN-1:0] v, input logic neg);
        return neg ? ({XLEN{1'b0}} - v) : v;
    endfunction

    function automatic logic [XLEN-1:0] mag(input logic [XLEN-1:0] v, input logic sgn_en);
        return neg_if(v, sgn_en & v[XLEN-1]);
    endfunction

endpackage

// File: rtl/muldiv_iter_core.sv
// Iterative datapath: shift-add multiply and restoring divide on magnitudes, plus sign fix-up.
// The restoring-divide slice exists only when HILO_MULDIV_DIV_EN is defined.
module muldiv_iter_core
    import hilo_muldiv_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load_i,
    input  logic            step_i,
    input  logic            is_div_i,
    input  logic            is_signed_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    output logic [XLEN-1:0] res_hi_o,
    output logic [XLEN-1:0] res_lo_o
);

    logic [XLEN-1:0]   hi_q, hi_d, lo_q, lo_d, opnd_q, opnd_d;
    logic              neg_q, neg_d, rneg_q, rneg_d, div_q, div_d;
    logic [XLEN:0]     mul_sum_s;
    logic [XLEN-1:0]   div_hi_s, div_lo_s;
    logic [2*XLEN-1:0] prod_s;

    assign mul_sum_s = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : {(XLEN+1){1'b0}});

`ifdef HILO_MULDIV_DIV_EN
    logic [XLEN:0]   div_shift_s;
    logic [XLEN-1:0] div_diff_s;
    logic            div_ge_s;

    // Shift in the next dividend bit; keep the difference only when it does not underflow.
    assign div_shift_s = {hi_q, lo_q[XLEN-1]};
    assign div_ge_s    = (div_shift_s >= {1'b0, opnd_q});
    assign div_diff_s  = div_shift_s[XLEN-1:0] - opnd_q;
    assign div_hi_s    = div_ge_s ? div_diff_s : div_shift_s[XLEN-1:0];
    assign div_lo_s    = {lo_q[XLEN-2:0], div_ge_s};
`else
    assign div_hi_s = hi_q;
    assign div_lo_s = lo_q;
`endif

    // Datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi_q   <= {XLEN{1'b0}};
            lo_q   <= {XLEN{1'b0}};
            opnd_q <= {XLEN{1'b0}};
            neg_q  <= 1'b0;
            rneg_q <= 1'b0;
            div_q  <= 1'b0;
        end else begin
            hi_q   <= hi_d;
            lo_q   <= lo_d;
            opnd_q <= opnd_d;
            neg_q  <= neg_d;
            rneg_q <= rneg_d;
            div_q  <= div_d;
        end
    end

    // Load magnitudes on accept, then advance one multiply or divide step per enabled cycle.
    always_comb begin
        hi_d   = hi_q;
        lo_d   = lo_q;
        opnd_d = opnd_q;
        neg_d  = neg_q;
        rneg_d = rneg_q;
        div_d  = div_q;
        if (load_i) begin
            div_d  = is_div_i;
            neg_d  = is_signed_i & (a_i[XLEN-1] ^ b_i[XLEN-1]);
            rneg_d = is_signed_i & a_i[XLEN-1];
            hi_d   = {XLEN{1'b0}};
            if (is_div_i) begin
                lo_d   = mag(a_i, is_signed_i);
                opnd_d = mag(b_i, is_signed_i);
            end else begin
                lo_d   = mag(b_i, is_signed_i);
                opnd_d = mag(a_i, is_signed_i);
            end
        end else if (step_i) begin
            if (div_q) begin
                hi_d = div_hi_s;
                lo_d = div_lo_s;
            end else begin
                hi_d = mul_sum_s[XLEN:1];
                lo_d = {mul_sum_s[0], lo_q[XLEN-1:1]};
            end
        end else begin
            hi_d = hi_q;
            lo_d = lo_q;
        end
    end

    assign prod_s = {hi_q, lo_q};

    // Sign fix: quotient truncates toward zero, remainder follows the dividend.
    always_comb begin
        if (div_q) begin
            res_hi_o = neg_if(hi_q, rneg_q);
            res_lo_o = neg_if(lo_q, neg_q);
        end else begin
            {res_hi_o, res_lo_o} = neg_q ? ({(2*XLEN){1'b0}} - prod_s) : prod_s;
        end
    end

endmodule

// File: rtl/hilo_muldiv_ctrl.sv
// HI/LO multiply/divide controller: request handshake, IDLE/CALC/FIX sequencing and HI/LO registers.
// DIV/DIVU are executed only when built with HILO_MULDIV_DIV_EN; otherwise they behave as reserved codes.
module hilo_muldiv_ctrl
    import hilo_muldiv_pkg::*;
#(
    parameter int WIDTH = XLEN
)(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             op_valid,
    output logic             op_ready,
    input  logic [2:0]       op_code,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             done,
    output logic             div_by_zero
);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
    logic               done_q, done_d, dbz_q, dbz_d;
    logic               accept_s, is_mul_s, is_div_s, div_zero_s, iter_start_s, is_signed_s;
    logic               step_s, fix_s;
    logic [WIDTH-1:0]   core_hi_s, core_lo_s;

    assign accept_s     = op_valid & op_ready;
    assign is_mul_s     = (op_code == OP_MULT) || (op_code == OP_MULTU);
    assign is_div_s     = DIV_EN && ((op_code == OP_DIV) || (op_code == OP_DIVU));
    assign is_signed_s  = (op_code == OP_MULT) || (op_code == OP_DIV);
    assign div_zero_s   = is_div_s && (rt_val == {WIDTH{1'b0}});
    assign iter_start_s = is_mul_s || (is_div_s && !div_zero_s);

    muldiv_iter_core u_core (
        .clk         (clk),
        .rst_n       (rst_n),
        .load_i      (accept_s & iter_start_s),
        .step_i      (step_s),
        .is_div_i    (is_div_s),
        .is_signed_i (is_signed_s),
        .a_i         (rs_val),
        .b_i         (rt_val),
        .res_hi_o    (core_hi_s),
        .res_lo_o    (core_lo_s)
    );

    // State register and iteration counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= {CNT_W{1'b0}};
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic: CALC runs exactly ITER_N step edges before FIX.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_s && iter_start_s) begin
                    state_d = ST_CALC;
                    cnt_d   = {CNT_W{1'b0}};
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CALC: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_FIX;
                end else begin
                    cnt_d = cnt_q + 5'd1;
                end
            end
            ST_FIX:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Output decode from the state register.
    always_comb begin
        op_ready = 1'b0;
        busy     = 1'b0;
        step_s   = 1'b0;
        fix_s    = 1'b0;
        case (state_q)
            ST_IDLE: op_ready = 1'b1;
            ST_CALC: begin
                busy   = 1'b1;
                step_s = 1'b1;
            end
            ST_FIX: begin
                busy  = 1'b1;
                fix_s = 1'b1;
            end
            default: op_ready = 1'b0;
        endcase
    end

    // HI/LO and completion pulse registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi_q   <= {WIDTH{1'b0}};
            lo_q   <= {WIDTH{1'b0}};
            done_q <= 1'b0;
            dbz_q  <= 1'b0;
        end else begin
            hi_q   <= hi_d;
            lo_q   <= lo_d;
            done_q <= done_d;
            dbz_q  <= dbz_d;
        end
    end

    // HI/LO change only on the FIX edge or on a move accept.
    always_comb begin
        hi_d   = hi_q;
        lo_d   = lo_q;
        done_d = 1'b0;
        dbz_d  = 1'b0;
        if (fix_s) begin
            hi_d   = core_hi_s;
            lo_d   = core_lo_s;
            done_d = 1'b1;
        end else if (accept_s) begin
            done_d = !iter_start_s;
            dbz_d  = div_zero_s;
            if (op_code == OP_MTHI) begin
                hi_d = rs_val;
            end else if (op_code == OP_MTLO) begin
                lo_d = rs_val;
            end else begin
                hi_d = hi_q;
                lo_d = lo_q;
            end
        end else begin
            done_d = 1'b0;
            dbz_d  = 1'b0;
        end
    end

    assign hi          = hi_q;
    assign lo          = lo_q;
    assign done        = done_q;
    assign div_by_zero = dbz_q;

endmodule

// File: doc/hilo_muldiv_ctrl.md
HILO_MULDIV_CTRL -- requirements
Module: hilo_muldiv_ctrl

Interface
REQ-001 Parameter: WIDTH, 32, operand and HI/LO register width; only 32 is supported.
REQ-002 clk  in  1  sole clock; all state changes on rising edge.
REQ-003 rst_n  in  1  asynchronous, active-low reset.
REQ-004 op_valid  in  1  request present.
REQ-005 op_ready  out  1  controller can accept a request (state IDLE).
REQ-006 op_code  in  3  0=MULT, 1=MULTU, 2=DIV, 3=DIVU, 4=MTHI, 5=MTLO, 6/7=reserved.
REQ-007 rs_val  in  32  multiplicand, dividend, or MTHI/MTLO data.
REQ-008 rt_val  in  32  multiplier or divisor.
REQ-009 busy  out  1  iterative operation in progress; pipeline stall request.
REQ-010 hi  out  32  HI register.
REQ-011 lo  out  32  LO register.
REQ-012 done  out  1  one-cycle pulse marking operation completion.
REQ-013 div_by_zero  out  1  one-cycle pulse, coincident with done, for DIV/DIVU with rt_val==0.

Function
REQ-014 Accept occurs on a rising edge with op_valid&&op_ready; operands and op_code are latched on that edge; op_valid while op_ready=0 shall be ignored.
REQ-015 FSM states: IDLE, CALC, FIX; IDLE->CALC on accept of MULT/MULTU/DIV/DIVU (nonzero divisor), CALC->FIX after exactly 32 iteration edges, FIX->IDLE unconditionally.
REQ-016 MULT/MULTU: 32-step shift-add on operand magnitudes; {hi,lo} = full 64-bit product written on the FIX edge.
REQ-017 DIV/DIVU: 32-step restoring division on magnitudes; lo=quotient, hi=remainder written on the FIX edge.
REQ-018 Signed ops: operands converted to magnitude on accept; FIX applies sign; quotient truncates toward zero, remainder takes sign of dividend.
REQ-019 DIV 0x80000000 / 0xFFFFFFFF shall give lo=0x80000000, hi=0x00000000, no flag.
REQ-020 Latency: accept at edge E0, done high in the cycle after edge E33; op_ready reasserts in that same cycle; busy high from after E0 until E33.
REQ-021 MTHI/MTLO: hi or lo written on the accept edge; busy never asserted; done high the following cycle.
REQ-022 DIV/DIVU with rt_val==0: no iteration, hi/lo unchanged, done and div_by_zero high the cycle after accept.
REQ-023 Reserved op_code: accepted, no register change, done high the cycle after accept.
REQ-024 hi/lo shall hold their values in all cycles other than the defined write edges.

Reset
REQ-025 rst_n low at any time, including mid-CALC, shall immediately force state=IDLE, hi=0, lo=0, done=0, div_by_zero=0, busy=0, op_ready=1; the in-flight operation is discarded.
REQ-026 First accept possible on the first rising edge after rst_n deasserts.

Configuration
REQ-027 Macro HILO_MULDIV_DIV_EN defined: DIV/DIVU implemented per REQ-017..REQ-022.
REQ-028 HILO_MULDIV_DIV_EN undefined: divider logic absent; DIV/DIVU handled as reserved codes (REQ-023); div_by_zero tied 0.

Structure
REQ-029 Shared package holds op_code enumeration constants, FSM state encoding, and iteration count (32).
REQ-030 The per-step datapath (shift-add/restoring-subtract accumulator, magnitude/sign-fix) shall be one sub-module, muldiv_iter_core; FSM, handshake and HI/LO live in the top.

Verification
REQ-031 MULT rs=0xFFFFFFFD (-3), rt=5 -> after 33 cycles hi=0xFFFFFFFF, lo=0xFFFFFFF1, done pulse one cycle.
REQ-032 MULTU rs=rt=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
REQ-033 DIV rs=0xFFFFFFF9 (-7), rt=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU rs=7, rt=0 -> next cycle done=div_by_zero=1, hi/lo unchanged.
REQ-034 MULT accepted, op_valid held high with MTHI during busy -> MTHI ignored until op_ready, then accepted; hi equals rs_val of MTHI afterwards.
REQ-035 rst_n pulsed low at cycle 10 of a MULT -> hi=lo=0, op_ready=1 immediately, no done pulse.
REQ-036 Build without HILO_MULDIV_DIV_EN: DIV rs=10, rt=3 -> done next cycle, hi/lo unchanged, div_by_zero=0.
